multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath: a Moore-style FSM that steps a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback. It replaces the single-cycle decoder when the processor moves to the multi-cycle organisation. It drives every datapath enable and mux select, and stretches memory states on a ready handshake.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; state returns to FETCH.
- OP  in  6  instruction register bits [31:26].
- Funct  in  6  instruction register bits [5:0].
- Zero  in  1  ALU zero flag from the current cycle.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if Zero=1 (beq).
- PCWriteCondNE  out  1  PC load if Zero=0 (bne).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  write-register select: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- Jal  out  1  forces write register $31 and write data PC.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- ALUOp  out  3  ALUOp to ALUControl.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- IllegalOp  out  1  one-cycle pulse on an unknown opcode.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.
- State  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_COMPLETE, BRANCH, I_EXECUTE, I_COMPLETE, JUMP, JR.
- Any output not listed for a state is 0.
- **FETCH**
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - PCWrite and IRWrite equal MemReady.
  - Goes to DECODE when MemReady=1; otherwise holds.
- **DECODE**
  - ALUSrcA=0, ALUSrcB=11, ALUOp=ADD; this loads the branch target into ALUOut.
  - Next state by OP:
    - 0x00 with Funct 0x08 → JR
    - 0x00 otherwise → EXECUTE
    - 0x23, 0x2B → MEM_ADDR
    - 0x04, 0x05 → BRANCH
    - 0x08, 0x0C, 0x0D, 0x0F → I_EXECUTE
    - 0x02, 0x03 → JUMP
    - any other OP → FETCH, with IllegalOp=1 for this cycle.
- **MEM_ADDR**: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- **MEM_READ**: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEM_WB.
- **MEM_WB**: RegWrite=1, RegDst=0, MemtoReg=1, InstrDone=1. Goes to FETCH.
- **MEM_WRITE**: MemWrite=1, IorD=1. Holds until MemReady=1; InstrDone=MemReady. Then goes to FETCH.
- **EXECUTE**: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE. Goes to R_COMPLETE.
- **R_COMPLETE**: RegWrite=1, RegDst=1, InstrDone=1. Goes to FETCH.
- **BRANCH**
  - ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, InstrDone=1.
  - PCWriteCond=1 for beq; PCWriteCondNE=1 for bne.
  - Goes to FETCH.
- **I_EXECUTE**: ALUSrcA=1, ALUSrcB=10. ALUOp is ADD, AND, OR or LUI for 0x08, 0x0C, 0x0D, 0x0F respectively. Goes to I_COMPLETE.
- **I_COMPLETE**: RegWrite=1, RegDst=0, InstrDone=1. Goes to FETCH.
- **JUMP**
  - PCWrite=1, PCSource=10, InstrDone=1.
  - For OP 0x03, also Jal=1 and RegWrite=1; the PC still holds PC+4 in this cycle.
  - Goes to FETCH.
- **JR**: PCWrite=1, PCSource=11, InstrDone=1. Goes to FETCH.
- OP and Funct are sampled from the IR, which is stable after FETCH; the FSM keeps no opcode copy.

## Timing
- Reset:
  - While reset=0: State=FETCH.
  - All enables (PCWrite, PCWriteCond, PCWriteCondNE, MemRead, MemWrite, IRWrite, RegWrite, Jal, IllegalOp, InstrDone) are forced to 0 combinationally.
  - Selects hold their FETCH values.
- Reset asserted mid-instruction aborts immediately: a MemWrite in progress drops in the same cycle. Fetch restarts on the first clk edge after release.
- Cycles per instruction with MemReady tied to 1:
  - lw: 5
  - sw, R-type, I-type: 4
  - beq, bne, j, jal, jr: 3
- Each cycle with MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. No other state looks at MemReady.
- MemReady arriving in a non-memory state is ignored.
- State transitions occur only on the rising clk edge; all outputs are purely decoded from State plus MemReady/OP.

## Structure
- Package mc_ctrl_pkg holds:
  - state encoding, 4 bits, FETCH=0
  - opcode and funct constants
  - ALUOp encodings: ADD=000, SUB=001, AND=010, OR=011, LUI=100, RTYPE=111
  - ALUSrcB and PCSource encodings
- Sub-module mc_output_decode: combinational map from State, OP and MemReady to the control word. The top level holds only the state register and the next-state logic.

## Test plan
- **Reset**: reset=0 mid-MEM_WRITE → MemWrite=0 in the same cycle and State=0. After release, FETCH with MemRead=1.
- **R-type add with MemReady=1**: exactly 4 cycles. R_COMPLETE has RegWrite=1, RegDst=1 and InstrDone=1.
- **lw with MemReady low for 2 cycles in MEM_READ**: 7 cycles total. RegWrite=1 with MemtoReg=1 only in MEM_WB.
- **Branches**:
  - beq: BRANCH has PCWriteCond=1, PCSource=01, ALUOp=001.
  - bne: PCWriteCondNE=1 and PCWriteCond=0.
- **Jumps**:
  - jal (OP 0x03): JUMP has PCWrite=1, PCSource=10, Jal=1, RegWrite=1.
  - jr (OP 0, Funct 0x08): JR has PCSource=11 and RegWrite=0.
- **Illegal opcode** OP=0x3F: IllegalOp pulses for 1 cycle in DECODE, then FETCH, and no write enable is asserted.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes,
// ALUOp / mux select codes and the decoded control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADDR   = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WB     = 4'd4,
    S_MEM_WRITE  = 4'd5,
    S_EXECUTE    = 4'd6,
    S_R_COMPLETE = 4'd7,
    S_BRANCH     = 4'd8,
    S_I_EXECUTE  = 4'd9,
    S_I_COMPLETE = 4'd10,
    S_JUMP       = 4'd11,
    S_JR         = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCWriteCondNE;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       Jal;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic       InstrDone;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR fields and handshakes in, control word out.
interface mc_ctrl_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, Jal, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       IllegalOp, InstrDone;
  logic [3:0] State;

  modport master (
    input  OP, Funct, Zero, MemReady,
    output PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, Jal, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, IllegalOp, InstrDone, State
  );

  modport slave (
    output OP, Funct, Zero, MemReady,
    input  PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, Jal, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, IllegalOp, InstrDone, State
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Moore control-word decode: state plus OP/MemReady to every datapath control.
module mc_output_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.ALUSrcB = SRCB_4;
        ctrl_o.ALUOp   = ALU_ADD;
        ctrl_o.PCWrite = mem_ready_i;
        ctrl_o.IRWrite = mem_ready_i;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded
        ctrl_o.ALUSrcB   = SRCB_IMMSH;
        ctrl_o.ALUOp     = ALU_ADD;
        ctrl_o.IllegalOp = ~is_legal_op(op_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_IMM;
        ctrl_o.ALUOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.MemtoReg  = 1'b1;
        ctrl_o.InstrDone = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.MemWrite  = 1'b1;
        ctrl_o.IorD      = 1'b1;
        ctrl_o.InstrDone = mem_ready_i;
      end
      S_EXECUTE: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_B;
        ctrl_o.ALUOp   = ALU_RTYPE;
      end
      S_R_COMPLETE: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.RegDst    = 1'b1;
        ctrl_o.InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.ALUSrcA       = 1'b1;
        ctrl_o.ALUSrcB       = SRCB_B;
        ctrl_o.ALUOp         = ALU_SUB;
        ctrl_o.PCSource      = PCS_ALUOUT;
        ctrl_o.InstrDone     = 1'b1;
        ctrl_o.PCWriteCond   = (op_i == OP_BEQ);
        ctrl_o.PCWriteCondNE = (op_i == OP_BNE);
      end
      S_I_EXECUTE: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_IMM;
        case (op_i)
          OP_ANDI: ctrl_o.ALUOp = ALU_AND;
          OP_ORI:  ctrl_o.ALUOp = ALU_OR;
          OP_LUI:  ctrl_o.ALUOp = ALU_LUI;
          default: ctrl_o.ALUOp = ALU_ADD;
        endcase
      end
      S_I_COMPLETE: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.InstrDone = 1'b1;
      end
      S_JUMP: begin
        // jal links PC+4: PC is not overwritten until the end of this cycle
        ctrl_o.PCWrite   = 1'b1;
        ctrl_o.PCSource  = PCS_JUMP;
        ctrl_o.InstrDone = 1'b1;
        ctrl_o.Jal       = (op_i == OP_JAL);
        ctrl_o.RegWrite  = (op_i == OP_JAL);
      end
      S_JR: begin
        ctrl_o.PCWrite   = 1'b1;
        ctrl_o.PCSource  = PCS_RS;
        ctrl_o.InstrDone = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, next-state logic and reset gating
// of the decoded control word.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl_raw, ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.OP)
          OP_RTYPE:                        state_d = (bus.Funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXECUTE;
          OP_J, OP_JAL:                    state_d = S_JUMP;
          default:                         state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.OP == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.MemReady) state_d = S_MEM_WB;
      S_MEM_WRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_COMPLETE;
      S_I_EXECUTE: state_d = S_I_COMPLETE;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_dec (
    .state_i     (state_q),
    .op_i        (bus.OP),
    .mem_ready_i (bus.MemReady),
    .ctrl_o      (ctrl_raw)
  );

  // Enables drop the instant reset asserts; selects fall back to FETCH via state_q
  always_comb begin
    ctrl = ctrl_raw;
    if (!reset) begin
      ctrl.PCWrite       = 1'b0;
      ctrl.PCWriteCond   = 1'b0;
      ctrl.PCWriteCondNE = 1'b0;
      ctrl.MemRead       = 1'b0;
      ctrl.MemWrite      = 1'b0;
      ctrl.IRWrite       = 1'b0;
      ctrl.RegWrite      = 1'b0;
      ctrl.Jal           = 1'b0;
      ctrl.IllegalOp     = 1'b0;
      ctrl.InstrDone     = 1'b0;
    end
  end

  assign bus.PCWrite       = ctrl.PCWrite;
  assign bus.PCWriteCond   = ctrl.PCWriteCond;
  assign bus.PCWriteCondNE = ctrl.PCWriteCondNE;
  assign bus.IorD          = ctrl.IorD;
  assign bus.MemRead       = ctrl.MemRead;
  assign bus.MemWrite      = ctrl.MemWrite;
  assign bus.IRWrite       = ctrl.IRWrite;
  assign bus.MemtoReg      = ctrl.MemtoReg;
  assign bus.RegDst        = ctrl.RegDst;
  assign bus.RegWrite      = ctrl.RegWrite;
  assign bus.Jal           = ctrl.Jal;
  assign bus.ALUSrcA       = ctrl.ALUSrcA;
  assign bus.ALUSrcB       = ctrl.ALUSrcB;
  assign bus.ALUOp         = ctrl.ALUOp;
  assign bus.PCSource      = ctrl.PCSource;
  assign bus.IllegalOp     = ctrl.IllegalOp;
  assign bus.InstrDone     = ctrl.InstrDone;
  assign bus.State         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle sequences for the multi-cycle sequencer, checked against
// hand-written control words through a scoreboard queue.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mc_ctrl_if bus();

  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // enable/flag bit positions in the 13-bit expected mask
  localparam logic [12:0] PCW  = 13'h1000, PCWC = 13'h0800, PCWN = 13'h0400,
                          IORD = 13'h0200, MRD  = 13'h0100, MWR  = 13'h0080,
                          IRW  = 13'h0040, M2R  = 13'h0020, RDST = 13'h0010,
                          REGW = 13'h0008, JAL  = 13'h0004, ILL  = 13'h0002,
                          DONE = 13'h0001;

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] en;
    logic        a;
    logic [1:0]  b;
    logic [2:0]  alu;
    logic [1:0]  pcs;
  } obs_t;

  typedef struct {
    obs_t  v;
    string nm;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic [3:0] st, input logic [12:0] en,
                      input logic a, input logic [1:0] b, input logic [2:0] alu,
                      input logic [1:0] pcs, input string nm);
    exp_t e;
    reset        = rst;
    bus.OP       = op;
    bus.Funct    = fn;
    bus.MemReady = mr;
    bus.Zero     = 1'b0;
    e.v  = '{st: st, en: en, a: a, b: b, alu: alu, pcs: pcs};
    e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // monitor: outputs are presented every cycle, checked mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = q.pop_front();
      o.st  = bus.State;
      o.en  = {bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNE, bus.IorD,
               bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
               bus.RegDst, bus.RegWrite, bus.Jal, bus.IllegalOp, bus.InstrDone};
      o.a   = bus.ALUSrcA;
      o.b   = bus.ALUSrcB;
      o.alu = bus.ALUOp;
      o.pcs = bus.PCSource;
      n_chk++;
      if (o !== e.v) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got st=%0d en=%h A=%0d B=%0d aluop=%0d pcsrc=%0d, expected st=%0d en=%h A=%0d B=%0d aluop=%0d pcsrc=%0d",
                 e.nm, cyc, o.st, o.en, o.a, o.b, o.alu, o.pcs,
                 e.v.st, e.v.en, e.v.a, e.v.b, e.v.alu, e.v.pcs);
      end
    end
  end

  initial begin
    bus.OP = '0; bus.Funct = '0; bus.MemReady = 1'b0; bus.Zero = 1'b0;
    @(posedge clk);
    #1;
    //   rst op     fn     mr st  en                 A  B  alu pcs name
    step(0, 6'h00, 6'h20, 1, 0,  '0,                0, 1, 0,  0, "reset.state");
    // add: 4 cycles
    step(1, 6'h00, 6'h20, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "add.fetch");
    step(1, 6'h00, 6'h20, 1, 1,  '0,                0, 3, 0,  0, "add.decode");
    step(1, 6'h00, 6'h20, 1, 6,  '0,                1, 0, 7,  0, "add.execute");
    step(1, 6'h00, 6'h20, 1, 7,  REGW|RDST|DONE,    0, 0, 0,  0, "add.rcomplete");
    // lw with two wait cycles in MEM_READ: 7 cycles
    step(1, 6'h23, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "lw.fetch");
    step(1, 6'h23, 6'h00, 0, 1,  '0,                0, 3, 0,  0, "lw.decode");
    step(1, 6'h23, 6'h00, 1, 2,  '0,                1, 2, 0,  0, "lw.memaddr");
    step(1, 6'h23, 6'h00, 0, 3,  IORD|MRD,          0, 0, 0,  0, "lw.memread.w1");
    step(1, 6'h23, 6'h00, 0, 3,  IORD|MRD,          0, 0, 0,  0, "lw.memread.w2");
    step(1, 6'h23, 6'h00, 1, 3,  IORD|MRD,          0, 0, 0,  0, "lw.memread.rdy");
    step(1, 6'h23, 6'h00, 0, 4,  REGW|M2R|DONE,     0, 0, 0,  0, "lw.memwb");
    // sw with one fetch stall
    step(1, 6'h2B, 6'h00, 0, 0,  MRD,               0, 1, 0,  0, "sw.fetch.wait");
    step(1, 6'h2B, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "sw.fetch");
    step(1, 6'h2B, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "sw.decode");
    step(1, 6'h2B, 6'h00, 1, 2,  '0,                1, 2, 0,  0, "sw.memaddr");
    step(1, 6'h2B, 6'h00, 1, 5,  MWR|IORD|DONE,     0, 0, 0,  0, "sw.memwrite");
    // beq / bne
    step(1, 6'h04, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "beq.fetch");
    step(1, 6'h04, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "beq.decode");
    step(1, 6'h04, 6'h00, 1, 8,  PCWC|DONE,         1, 0, 1,  1, "beq.branch");
    step(1, 6'h05, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "bne.fetch");
    step(1, 6'h05, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "bne.decode");
    step(1, 6'h05, 6'h00, 1, 8,  PCWN|DONE,         1, 0, 1,  1, "bne.branch");
    // I-type: ori, lui
    step(1, 6'h0D, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "ori.fetch");
    step(1, 6'h0D, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "ori.decode");
    step(1, 6'h0D, 6'h00, 1, 9,  '0,                1, 2, 3,  0, "ori.iexec");
    step(1, 6'h0D, 6'h00, 1, 10, REGW|DONE,         0, 0, 0,  0, "ori.icomplete");
    step(1, 6'h0F, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "lui.fetch");
    step(1, 6'h0F, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "lui.decode");
    step(1, 6'h0F, 6'h00, 1, 9,  '0,                1, 2, 4,  0, "lui.iexec");
    step(1, 6'h0F, 6'h00, 1, 10, REGW|DONE,         0, 0, 0,  0, "lui.icomplete");
    // jumps
    step(1, 6'h03, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "jal.fetch");
    step(1, 6'h03, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "jal.decode");
    step(1, 6'h03, 6'h00, 1, 11, PCW|JAL|REGW|DONE, 0, 0, 0,  2, "jal.jump");
    step(1, 6'h02, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "j.fetch");
    step(1, 6'h02, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "j.decode");
    step(1, 6'h02, 6'h00, 1, 11, PCW|DONE,          0, 0, 0,  2, "j.jump");
    step(1, 6'h00, 6'h08, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "jr.fetch");
    step(1, 6'h00, 6'h08, 1, 1,  '0,                0, 3, 0,  0, "jr.decode");
    step(1, 6'h00, 6'h08, 1, 12, PCW|DONE,          0, 0, 0,  3, "jr.jr");
    // illegal opcode
    step(1, 6'h3F, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "ill.fetch");
    step(1, 6'h3F, 6'h00, 1, 1,  ILL,               0, 3, 0,  0, "ill.decode");
    step(1, 6'h3F, 6'h00, 0, 0,  MRD,               0, 1, 0,  0, "ill.refetch");
    // sw aborted by reset while stalled in MEM_WRITE
    step(1, 6'h2B, 6'h00, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "rst.sw.fetch");
    step(1, 6'h2B, 6'h00, 1, 1,  '0,                0, 3, 0,  0, "rst.sw.decode");
    step(1, 6'h2B, 6'h00, 1, 2,  '0,                1, 2, 0,  0, "rst.sw.memaddr");
    step(1, 6'h2B, 6'h00, 0, 5,  MWR|IORD,          0, 0, 0,  0, "rst.sw.memwrite");
    step(0, 6'h2B, 6'h00, 0, 0,  '0,                0, 1, 0,  0, "rst.abort");
    step(1, 6'h00, 6'h20, 0, 0,  MRD,               0, 1, 0,  0, "rst.release.fetch");
    step(1, 6'h00, 6'h20, 1, 0,  PCW|MRD|IRW,       0, 1, 0,  0, "rst.refetch");
    step(1, 6'h00, 6'h20, 0, 1,  '0,                0, 3, 0,  0, "rst.decode");
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard.drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
